// File: rtl/acc_drain_pkg.sv
// Shared types and the signed requantization helper for the accumulator drain stage.
package acc_drain_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Requant math runs at a fixed maximum width; callers sign-extend in and truncate out.
    localparam int unsigned RQ_W  = 64;
    localparam int unsigned RQ_W1 = RQ_W + 1;

    // Round-half-up arithmetic right shift, then saturate to a signed data_w-bit range.
    function automatic logic signed [RQ_W-1:0] requant(
        input logic signed [RQ_W-1:0] acc,
        input int unsigned            shift,
        input int unsigned            acc_w,
        input int unsigned            data_w
    );
        logic signed [RQ_W:0] rnd;
        logic signed [RQ_W:0] sum;
        logic signed [RQ_W:0] y;
        logic signed [RQ_W:0] hi;
        logic signed [RQ_W:0] lo;
        rnd = '0;
        sum = '0;
        if (shift != 32'd0) begin
            rnd = RQ_W1'(1) << (shift - 32'd1);
        end
        // Shifting by the full accumulator width leaves only the sign.
        if (shift >= acc_w) begin
            y = acc[RQ_W-1] ? '1 : '0;
        end else begin
            sum = {acc[RQ_W-1], acc} + rnd;
            y   = sum >>> shift;
        end
        hi = (RQ_W1'(1) << (data_w - 32'd1)) - RQ_W1'(1);
        lo = -(RQ_W1'(1) << (data_w - 32'd1));
        if (y > hi) begin
            y = hi;
        end else if (y < lo) begin
            y = lo;
        end
        return RQ_W'(y);
    endfunction

endpackage

// File: rtl/acc_drain_requant_row.sv
// Selects one row of the shadow accumulator array and requantizes every element of it.
module acc_drain_requant_row
    import acc_drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MATRIX_SIZE = 8,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned SHIFT_WIDTH = 5
) (
    input  logic [ACC_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] i_shadow,
    input  logic [$clog2(MATRIX_SIZE)-1:0]               i_row,
    input  logic [SHIFT_WIDTH-1:0]                       i_shift,
    output logic [DATA_WIDTH*MATRIX_SIZE-1:0]            o_row
);

    localparam int unsigned ROW_W = ACC_WIDTH * MATRIX_SIZE;

    logic [ROW_W-1:0]            w_row;
    logic [ACC_WIDTH-1:0]        w_elem;
    logic signed [RQ_W-1:0]      w_res;

    always_comb begin
        w_row  = i_shadow[32'(i_row) * ROW_W +: ROW_W];
        w_elem = '0;
        w_res  = '0;
        o_row  = '0;
        for (int j = 0; j < int'(MATRIX_SIZE); j++) begin
            w_elem = w_row[j*ACC_WIDTH +: ACC_WIDTH];
            w_res  = requant(RQ_W'($signed(w_elem)), 32'(i_shift), ACC_WIDTH, DATA_WIDTH);
            o_row[j*DATA_WIDTH +: DATA_WIDTH] = w_res[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/acc_drain.sv
// Snapshots the accumulator array on start, clears the array, and streams requantized rows out.
module acc_drain
    import acc_drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MATRIX_SIZE = 8,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned SHIFT_WIDTH = 5
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [SHIFT_WIDTH-1:0]                       shift_amt,
    input  logic [ACC_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] acc_in_flat,
    output logic                                         acc_rst_req,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [$clog2(MATRIX_SIZE)-1:0]               out_row_idx,
    output logic                                         out_last,
    output logic [DATA_WIDTH*MATRIX_SIZE-1:0]            out_data_flat
);

    localparam int unsigned RW    = $clog2(MATRIX_SIZE);
    localparam int unsigned ARR_W = ACC_WIDTH * MATRIX_SIZE * MATRIX_SIZE;
    localparam logic [RW-1:0] LAST_ROW = RW'(MATRIX_SIZE - 1);

    state_e                 r_state;
    state_e                 w_next_state;
    logic [ARR_W-1:0]       r_shadow;
    logic [SHIFT_WIDTH-1:0] r_shift_q;
    logic [RW-1:0]          r_row;
    logic                   r_acc_rst_req;
    logic                   r_done;
    logic                   w_capture;
    logic                   w_beat;
    logic                   w_last_beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_beat       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    w_beat = 1'b1;
                    if (r_row == LAST_ROW) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        w_last_beat = w_beat && (r_row == LAST_ROW);
    end

    // Snapshot, row counter and single-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow      <= '0;
            r_shift_q     <= '0;
            r_row         <= '0;
            r_acc_rst_req <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_acc_rst_req <= w_capture;
            r_done        <= w_last_beat;
            if (w_capture) begin
                r_shadow  <= acc_in_flat;
                r_shift_q <= shift_amt;
                r_row     <= '0;
            end else if (w_last_beat) begin
                r_row <= '0;
            end else if (w_beat) begin
                r_row <= r_row + RW'(1);
            end
        end
    end

    assign busy        = (r_state == ST_DRAIN);
    assign out_valid   = (r_state == ST_DRAIN);
    assign out_last    = (r_state == ST_DRAIN) && (r_row == LAST_ROW);
    assign out_row_idx = r_row;
    assign acc_rst_req = r_acc_rst_req;
    assign done        = r_done;

    acc_drain_requant_row #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MATRIX_SIZE (MATRIX_SIZE),
        .ACC_WIDTH   (ACC_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant_row (
        .i_shadow (r_shadow),
        .i_row    (r_row),
        .i_shift  (r_shift_q),
        .o_row    (out_data_flat)
    );

endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain: capture, requant rounding/saturation, backpressure, reset.
module tb_acc_drain;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [SW-1:0]     shift_amt;
    logic [AW*N*N-1:0] acc_in_flat;
    logic              acc_rst_req;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_row_idx;
    logic              out_last;
    logic [DW*N-1:0]   out_data_flat;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    acc_drain #(
        .DATA_WIDTH  (DW),
        .MATRIX_SIZE (N),
        .ACC_WIDTH   (AW),
        .SHIFT_WIDTH (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .shift_amt     (shift_amt),
        .acc_in_flat   (acc_in_flat),
        .acc_rst_req   (acc_rst_req),
        .busy          (busy),
        .done          (done),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_row_idx   (out_row_idx),
        .out_last      (out_last),
        .out_data_flat (out_data_flat)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_acc(input int i, input int j, input logic [31:0] v);
        acc_in_flat[(i*int'(N)+j)*int'(AW) +: AW] = v;
    endtask

    // Row r of a tile whose element (i,j) requantizes to i*8+j.
    function automatic logic [63:0] seq_row(input int r);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < 8; j++) v[j*8 +: 8] = 8'(r*8 + j);
        return v;
    endfunction

    initial begin
        int exp_r;
        int cyc;
        rst         = 1'b0;
        start       = 1'b0;
        shift_amt   = '0;
        acc_in_flat = '0;
        out_ready   = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_acc_rst_req", 64'(acc_rst_req), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", out_data_flat, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Tile A: s=0, element (i,j) = i*8+j; a start mid-drain must be ignored.
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) set_acc(i, j, 32'(i*8 + j));
        shift_amt = 5'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("a_acc_rst_req_k1", 64'(acc_rst_req), 64'd1);
        check("a_busy_k1", 64'(busy), 64'd1);
        for (int r = 0; r < 8; r++) begin
            check("a_valid", 64'(out_valid), 64'd1);
            check("a_row_idx", 64'(out_row_idx), 64'(r));
            check("a_last", 64'(out_last), 64'(r == 7));
            check("a_data", out_data_flat, seq_row(r));
            if (r > 0) check("a_acc_rst_req_low", 64'(acc_rst_req), 64'd0);
            if (r == 2) begin
                acc_in_flat = '1;
                shift_amt   = 5'd3;
                start       = 1'b1;
            end
            if (r == 3) start = 1'b0;
            if (r < 7) @(negedge clk);
        end
        @(negedge clk);
        check("a_done", 64'(done), 64'd1);
        check("a_busy_end", 64'(busy), 64'd0);
        check("a_valid_end", 64'(out_valid), 64'd0);
        check("a_no_extra_clear", 64'(acc_rst_req), 64'd0);

        // Tile B started in the done cycle: s=4 rounding and saturation in row 0.
        acc_in_flat = '0;
        set_acc(0, 0, 32'sd24);
        set_acc(0, 1, 32'sd23);
        set_acc(0, 2, -32'sd24);
        set_acc(0, 3, -32'sd25);
        set_acc(0, 4, 32'sd5000);
        set_acc(0, 5, -32'sd5000);
        set_acc(0, 6, 32'sd0);
        set_acc(0, 7, 32'sd8);
        shift_amt = 5'd4;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b_valid_b2b", 64'(out_valid), 64'd1);
        check("b_acc_rst_req", 64'(acc_rst_req), 64'd1);
        check("b_done_low", 64'(done), 64'd0);
        check("b_row_idx", 64'(out_row_idx), 64'd0);
        check("b_round_sat", out_data_flat, 64'h0100_807F_FEFF_0102);
        @(negedge clk);
        check("b_row1_zero", out_data_flat, 64'd0);
        repeat (6) @(negedge clk);
        check("b_last", 64'(out_last), 64'd1);
        @(negedge clk);
        check("b_done", 64'(done), 64'd1);

        // Tile C back-to-back: s=31 rounding boundaries around the sign bit.
        acc_in_flat = '0;
        set_acc(0, 0, 32'h8000_0000);
        set_acc(0, 1, 32'h7FFF_FFFF);
        set_acc(0, 2, 32'hFFFF_FFFB);
        set_acc(0, 3, 32'h4000_0000);
        set_acc(0, 4, 32'h3FFF_FFFF);
        shift_amt = 5'd31;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("c_shift31", out_data_flat, 64'h0000_0000_0100_01FF);
        repeat (3) @(negedge clk);
        check("c_row3", 64'(out_row_idx), 64'd3);

        // Asynchronous reset in the middle of the drain.
        #2 rst = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_row", 64'(out_row_idx), 64'd0);
        check("rst_mid_data", out_data_flat, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'd0);

        // Tile D with random backpressure: x = 16*v + 7, s=4 -> v.
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) set_acc(i, j, 32'(16*(i*8 + j) + 7));
        shift_amt = 5'd4;
        out_ready = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_r = 0;
        cyc   = 0;
        while (exp_r < 8 && cyc < 400) begin
            check("d_valid", 64'(out_valid), 64'd1);
            check("d_row_idx", 64'(out_row_idx), 64'(exp_r));
            check("d_last", 64'(out_last), 64'(exp_r == 7));
            check("d_data", out_data_flat, seq_row(exp_r));
            out_ready = ($urandom_range(0, 9) < 3);
            if (out_ready) exp_r++;
            cyc++;
            @(negedge clk);
        end
        check("d_all_rows", 64'(exp_r), 64'd8);
        check("d_done", 64'(done), 64'd1);
        check("d_valid_end", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("d_done_pulse", 64'(done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
